mem_bank_pipe: RTL and testbench

//  Parametrised single-port synchronous memory; successor to the 8-bit ce/we memory.

---
 rtl/mem_bank_if.sv | 27 ++
 rtl/mem_bank_pipe.sv | 164 ++++++++++++++++
 tb/tb_mem_bank_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_if.sv
// mem_bank_if: request/response bundle for the mem_bank_pipe RAM target.
// The master side issues requests and consumes responses; the slave is the memory.
interface mem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bank_pipe.sv
// mem_bank_pipe: single-port synchronous RAM with byte-lane writes, an RD_LAT-deep
// read pipeline and a first-word-fall-through response buffer. Read credits
// (outstanding reads) are capped at RSP_DEPTH so the buffer can never overflow.
// Optional feature macro: MEM_BANK_PARITY_EN (per-byte even parity + inj_perr port).
module mem_bank_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  mem_bank_if.slave bus
`ifdef MEM_BANK_PARITY_EN
  ,
  input logic       inj_perr
`endif
);
  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C     = DEPTH[ADDR_W:0];
  localparam logic [CW-1:0]   RSP_DEPTH_C = RSP_DEPTH[CW-1:0];
  localparam logic [PW-1:0]   LAST_PTR_C  = PW'(RSP_DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef MEM_BANK_PARITY_EN
  logic [NB-1:0]     par_q [DEPTH];
  logic [NB-1:0]     perrBits;
`endif

  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [DATA_W-1:0] fData_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fErr_q;

  logic [IW-1:0]     memIdx;
  logic              inRange, reqReady, accept, rdAcc, wrAcc, pop, rspValid;
  logic [DATA_W-1:0] rdData;
  logic              rdErr;
  logic              pushV, pushE;
  logic [DATA_W-1:0] pushD;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR_C) ? '0 : p + 1'b1;
  endfunction

  // Request-side decode: range check, credit-based ready and accept strobes.
  always_comb begin
    memIdx   = bus.req_addr[IW-1:0];
    inRange  = ({1'b0, bus.req_addr} < DEPTH_C);
    reqReady = reset && (outst_q < RSP_DEPTH_C);
    accept   = bus.req_valid && reqReady;
    rdAcc    = accept && !bus.req_we;
    wrAcc    = accept && bus.req_we;
    rspValid = (cnt_q != '0);
    pop      = rspValid && bus.rsp_ready;
  end

`ifdef MEM_BANK_PARITY_EN
  // Array sample for a read, with range error and any byte-lane parity mismatch.
  always_comb begin
    perrBits = '0;
    for (int i = 0; i < NB; i++)
      perrBits[i] = (^mem_q[memIdx][8*i +: 8]) ^ par_q[memIdx][i];
    rdData = inRange ? mem_q[memIdx] : '0;
    rdErr  = !inRange || (|perrBits);
  end
`else
  // Array sample for a read; out-of-range addresses return zero with an error.
  always_comb begin
    rdData = inRange ? mem_q[memIdx] : '0;
    rdErr  = !inRange;
  end
`endif

  // Byte-lane write port; out-of-range writes are dropped, contents never reset.
  always_ff @(posedge clk) begin
    if (wrAcc && inRange) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.req_be[i]) begin
          mem_q[memIdx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
`ifdef MEM_BANK_PARITY_EN
          par_q[memIdx][i] <= (^bus.req_wdata[8*i +: 8]) ^ inj_perr;
`endif
        end
      end
    end
  end

  // The last pipeline stage is the buffer write itself, so RD_LAT-1 registers sit before it.
  generate
    if (RD_LAT == 1) begin : g_noPipe
      assign pushV = rdAcc;
      assign pushD = rdData;
      assign pushE = rdErr;
    end else begin : g_pipe
      logic [RD_LAT-2:0] pv_q;
      logic [RD_LAT-2:0] pe_q;
      logic [DATA_W-1:0] pd_q [RD_LAT-1];

      // Shift read results toward the buffer; a reset discards anything in flight.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pv_q <= '0;
          pe_q <= '0;
          for (int k = 0; k < RD_LAT - 1; k++) pd_q[k] <= '0;
        end else begin
          pv_q[0] <= rdAcc;
          pe_q[0] <= rdErr;
          pd_q[0] <= rdData;
          for (int k = 1; k < RD_LAT - 1; k++) begin
            pv_q[k] <= pv_q[k-1];
            pe_q[k] <= pe_q[k-1];
            pd_q[k] <= pd_q[k-1];
          end
        end
      end

      assign pushV = pv_q[RD_LAT-2];
      assign pushD = pd_q[RD_LAT-2];
      assign pushE = pe_q[RD_LAT-2];
    end
  endgenerate

  // Next-state for credits and buffer pointers; push and pop together leave counts unchanged.
  always_comb begin
    outst_d = outst_q + CW'(rdAcc) - CW'(pop);
    cnt_d   = cnt_q + CW'(pushV) - CW'(pop);
    wp_d    = pushV ? nextPtr(wp_q) : wp_q;
    rp_d    = pop ? nextPtr(rp_q) : rp_q;
  end

  // Credit counter and buffer control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outst_q <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // Response buffer storage; the count register alone decides what is valid.
  always_ff @(posedge clk) begin
    if (pushV) begin
      fData_q[wp_q] <= pushD;
      fErr_q[wp_q]  <= pushE;
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspValid ? fData_q[rp_q] : '0;
  assign bus.rsp_err   = rspValid && fErr_q[rp_q];
endmodule

// File: tb/tb_mem_bank_pipe.sv
// tb_mem_bank_pipe: directed table-driven bench for mem_bank_pipe
// (DEPTH=200, RD_LAT=2, RSP_DEPTH=4), plus hand sequences for backpressure,
// reset mid-operation and, with MEM_BANK_PARITY_EN, parity error injection.
module tb_mem_bank_pipe;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  logic clk;
  logic reset;
`ifdef MEM_BANK_PARITY_EN
  logic inj_perr;
`endif
  int total;
  int bad;
  vec_t vecs[$];

  mem_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_bank_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(200), .RD_LAT(2), .RSP_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus)
`ifdef MEM_BANK_PARITY_EN
    ,
    .inj_perr(inj_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic [31:0] expData, input logic expErr);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.expData = expData; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request and hold it until accepted; returns 1 ns after the accept edge.
  task automatic sendReq(input logic we, input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bit done;
    done = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.req_ready === 1'b1) done = 1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout addr %0d: got no accept expected accept", addr);
    end
  endtask

  // Read with rsp_ready high and an empty buffer: checks the two-cycle latency and the payload.
  task automatic doRead(input logic [7:0] addr, input logic [31:0] expData, input logic expErr);
    sendReq(1'b0, addr, '0, '0);
    checkOutput($sformatf("rd%0d_early", addr), {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput($sformatf("rd%0d_valid", addr), {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput($sformatf("rd%0d_data", addr), bus.rsp_rdata, expData);
    checkOutput($sformatf("rd%0d_err", addr), {31'b0, bus.rsp_err}, {31'b0, expErr});
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a response, compare it, then pop it.
  task automatic popResp(input string name, input logic [31:0] expData, input logic expErr);
    bit done;
    done = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (bus.rsp_valid === 1'b1) begin
        checkOutput({name, "_data"}, bus.rsp_rdata, expData);
        checkOutput({name, "_err"}, {31'b0, bus.rsp_err}, {31'b0, expErr});
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no response expected response", name);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.we) sendReq(1'b1, v.addr, v.wdata, v.be);
    else doRead(v.addr, v.expData, v.expErr);
  endtask

  initial begin
    int stale;
    total = 0;
    bad = 0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;
`ifdef MEM_BANK_PARITY_EN
    inj_perr = 1'b0;
`endif

    // Directed vectors: fill, byte-lane merge, no-op write, range errors.
    for (int i = 0; i < 8; i++) vecs.push_back(mkVec(1'b1, 8'(i), 32'hA0 + 32'(i), 4'hF, '0, 1'b0));
    for (int i = 0; i < 8; i++) vecs.push_back(mkVec(1'b0, 8'(i), '0, '0, 32'hA0 + 32'(i), 1'b0));
    vecs.push_back(mkVec(1'b1, 8'd5,   32'h11223344, 4'hF,    '0, 1'b0));
    vecs.push_back(mkVec(1'b1, 8'd5,   32'hAABBCCDD, 4'b0101, '0, 1'b0));
    vecs.push_back(mkVec(1'b0, 8'd5,   '0, '0, 32'h11BB33DD, 1'b0));
    vecs.push_back(mkVec(1'b1, 8'd6,   32'hFFFFFFFF, 4'h0,    '0, 1'b0));
    vecs.push_back(mkVec(1'b0, 8'd6,   '0, '0, 32'h000000A6, 1'b0));
    vecs.push_back(mkVec(1'b0, 8'd200, '0, '0, 32'h0, 1'b1));
    vecs.push_back(mkVec(1'b1, 8'd199, 32'hCAFEF00D, 4'hF,    '0, 1'b0));
    vecs.push_back(mkVec(1'b1, 8'd200, 32'hDEADBEEF, 4'hF,    '0, 1'b0));
    vecs.push_back(mkVec(1'b0, 8'd199, '0, '0, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mkVec(1'b0, 8'd200, '0, '0, 32'h0, 1'b1));
    vecs.push_back(mkVec(1'b0, 8'd255, '0, '0, 32'h0, 1'b1));

    // Reset state held for 10 cycles.
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Backpressure: four reads fill the credits, responses are held, then drained in order.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) sendReq(1'b0, 8'(i), '0, '0);
    checkOutput("bp_ready_low", {31'b0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput("bp_hold_data0", bus.rsp_rdata, 32'hA0);
    @(posedge clk);
    #1;
    checkOutput("bp_hold_data1", bus.rsp_rdata, 32'hA0);
    checkOutput("bp_still_full", {31'b0, bus.req_ready}, 32'd0);
    popResp("bp_rsp0", 32'hA0, 1'b0);
    checkOutput("bp_ready_back", {31'b0, bus.req_ready}, 32'd1);
    popResp("bp_rsp1", 32'hA1, 1'b0);
    popResp("bp_rsp2", 32'hA2, 1'b0);
    popResp("bp_rsp3", 32'hA3, 1'b0);
    doRead(8'd4, 32'hA4, 1'b0);
    doRead(8'd5, 32'h11BB33DD, 1'b0);

    // Reset while three reads are in flight.
    sendReq(1'b0, 8'd0, '0, '0);
    sendReq(1'b0, 8'd1, '0, '0);
    sendReq(1'b0, 8'd2, '0, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("mid_rst_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("mid_rst_ready", {31'b0, bus.req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.rsp_valid !== 1'b0) stale++;
      @(posedge clk);
    end
    #1;
    checkOutput("no_stale_rsp", 32'(stale), 32'd0);
    checkOutput("rel_ready", {31'b0, bus.req_ready}, 32'd1);
    doRead(8'd5, 32'h11BB33DD, 1'b0);
    doRead(8'd199, 32'hCAFEF00D, 1'b0);

`ifdef MEM_BANK_PARITY_EN
    // Parity injection corrupts the stored check bits; a clean rewrite repairs them.
    inj_perr = 1'b1;
    sendReq(1'b1, 8'd3, 32'hFFFF0000, 4'hF);
    inj_perr = 1'b0;
    doRead(8'd3, 32'hFFFF0000, 1'b1);
    sendReq(1'b1, 8'd3, 32'hFFFF0000, 4'hF);
    doRead(8'd3, 32'hFFFF0000, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
